// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_pkg
// Purpose  : Shared types and constants for the execute-stage ALU and the
//            upstream ALU-operation decoder.
//            - alu_op_e      : 4-bit ALU operation code
//            - OP_IS_SHIFT   : per-opcode mask of iterative shift ops
//            - OP_IS_BRANCH  : per-opcode mask of branch-compare ops
//            - alu_state_e   : execute-unit FSM state encoding
// Revision : 1.0 - initial release
// ============================================================================
package alu_pkg;

    typedef enum logic [3:0] {
        OP_AND = 4'b0000,
        OP_OR  = 4'b0001,
        OP_ADD = 4'b0010,
        OP_SUB = 4'b0011,
        OP_XOR = 4'b0100,
        OP_BEQ = 4'b1000,
        OP_BNE = 4'b1001,
        OP_BLT = 4'b1010,
        OP_BGE = 4'b1011,
        OP_SLL = 4'b1100,
        OP_SRL = 4'b1101,
        OP_SLT = 4'b1110,
        OP_SRA = 4'b1111
    } alu_op_e;

    // Indexed by the opcode value: bit n set means opcode n belongs to the class.
    // Shifts are 1100 (SLL), 1101 (SRL), 1111 (SRA); 1110 is SLT, not a shift.
    localparam logic [15:0] OP_IS_SHIFT  = 16'hB000;
    localparam logic [15:0] OP_IS_BRANCH = 16'h0F00;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } alu_state_e;

endpackage : alu_pkg
`default_nettype wire

// File: rtl/alu_iter_shifter.sv
`default_nettype none
// ============================================================================
// Module   : alu_iter_shifter
// Purpose  : Iterative 1-bit-per-cycle shifter (SLL / SRL / SRA).
// Ports    : clk, rst        - clock, synchronous active-high reset
//            i_start         - load i_data / i_shamt / i_op (shamt must be > 0)
//            i_op            - shift kind, latched on i_start
//            i_data          - value to shift
//            i_shamt         - number of 1-bit steps
//            o_done          - the shift performed this cycle is the last one
//            o_result        - acc shifted by one more bit (valid with o_done)
// Revision : 1.0 - initial release
// ============================================================================
module alu_iter_shifter
    import alu_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int SHAMT_W = $clog2(DATA_W)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_start,
    input  alu_op_e             i_op,
    input  logic [DATA_W-1:0]   i_data,
    input  logic [SHAMT_W-1:0]  i_shamt,
    output logic                o_done,
    output logic [DATA_W-1:0]   o_result
);

    logic [DATA_W-1:0]  acc_q, acc_d;
    logic [SHAMT_W-1:0] cnt_q, cnt_d;
    alu_op_e            op_q, op_d;
    logic [DATA_W-1:0]  w_shifted;

    // One-bit step of the latched shift kind.
    always_comb begin
        case (op_q)
            OP_SLL:  w_shifted = {acc_q[DATA_W-2:0], 1'b0};
            OP_SRA:  w_shifted = {acc_q[DATA_W-1], acc_q[DATA_W-1:1]};
            default: w_shifted = {1'b0, acc_q[DATA_W-1:1]};
        endcase
    end

    // cnt counts remaining steps; zero means idle, so no shifting happens
    // outside an active operation.
    always_comb begin
        acc_d = acc_q;
        cnt_d = cnt_q;
        op_d  = op_q;
        if (i_start) begin
            acc_d = i_data;
            cnt_d = i_shamt;
            op_d  = i_op;
        end else if (cnt_q != '0) begin
            acc_d = w_shifted;
            cnt_d = cnt_q - SHAMT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
            cnt_q <= '0;
            op_q  <= OP_SLL;
        end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
            op_q  <= op_d;
        end
    end

    assign o_done   = (cnt_q == SHAMT_W'(1));
    assign o_result = w_shifted;

endmodule : alu_iter_shifter
`default_nettype wire

// File: rtl/alu_exec_unit.sv
`default_nettype none
// ============================================================================
// Module   : alu_exec_unit
// Purpose  : Execute-stage ALU with valid/ready handshakes. Logic, add/sub,
//            compare and branch-compare ops complete in one cycle; shifts
//            run on an iterative shifter (shamt + 1 cycles).
// Ports    : clk, reset            - clock, synchronous active-high reset
//            in_valid / in_ready   - input handshake (operation, src_a, src_b)
//            out_valid / out_ready - output handshake (result, zero)
//            busy                  - multi-cycle shift in progress
// Revision : 1.0 - initial release
// ============================================================================
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int SHAMT_W = $clog2(DATA_W)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  alu_op_e           operation,
    input  logic [DATA_W-1:0] src_a,
    input  logic [DATA_W-1:0] src_b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] result,
    output logic              zero,
    output logic              busy
);

    alu_state_e         state_q, state_d;
    logic [DATA_W-1:0]  result_q, result_d;
    logic               zero_q, zero_d;

    logic               w_accept;
    logic               w_is_shift;
    logic [SHAMT_W-1:0] w_shamt;
    logic               w_eq;
    logic               w_lt;
    logic               w_br_flag;
    logic [DATA_W-1:0]  w_alu_res;
    logic               w_shift_start;
    logic               w_shift_done;
    logic [DATA_W-1:0]  w_shift_res;

    assign w_accept   = in_valid && in_ready;
    assign w_is_shift = OP_IS_SHIFT[operation];
    assign w_shamt    = src_b[SHAMT_W-1:0];

    // ------------------------------------------------------------------
    // Single-cycle datapath. A shift reaching this path has shamt == 0,
    // so its result is simply src_a.
    // ------------------------------------------------------------------
    always_comb begin
        w_eq = (src_a == src_b);
        w_lt = ($signed(src_a) < $signed(src_b));
        // Branch op low bits: 00 BEQ, 01 BNE, 10 BLT, 11 BGE.
        case (operation[1:0])
            2'b00:   w_br_flag = w_eq;
            2'b01:   w_br_flag = !w_eq;
            2'b10:   w_br_flag = w_lt;
            default: w_br_flag = !w_lt;
        endcase

        w_alu_res = '0;
        if (OP_IS_BRANCH[operation]) begin
            w_alu_res = {{(DATA_W-1){1'b0}}, w_br_flag};
        end else begin
            case (operation)
                OP_AND:  w_alu_res = src_a & src_b;
                OP_OR:   w_alu_res = src_a | src_b;
                OP_ADD:  w_alu_res = src_a + src_b;
                OP_SUB:  w_alu_res = src_a - src_b;
                OP_XOR:  w_alu_res = src_a ^ src_b;
                OP_SLT:  w_alu_res = {{(DATA_W-1){1'b0}}, w_lt};
                OP_SLL,
                OP_SRL,
                OP_SRA:  w_alu_res = src_a;
                default: w_alu_res = '0;
            endcase
        end
    end

    alu_iter_shifter #(
        .DATA_W  (DATA_W),
        .SHAMT_W (SHAMT_W)
    ) u_shifter (
        .clk      (clk),
        .rst      (reset),
        .i_start  (w_shift_start),
        .i_op     (operation),
        .i_data   (src_a),
        .i_shamt  (w_shamt),
        .o_done   (w_shift_done),
        .o_result (w_shift_res)
    );

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            result_q <= '0;
            zero_q   <= 1'b1;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            zero_q   <= zero_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and result capture
    // ------------------------------------------------------------------
    always_comb begin
        state_d       = state_q;
        result_d      = result_q;
        w_shift_start = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                // DONE accepts a new op in the same cycle the old result
                // is consumed, which keeps single-cycle ops back-to-back.
                if (w_accept) begin
                    if (w_is_shift && (w_shamt != '0)) begin
                        w_shift_start = 1'b1;
                        state_d       = ST_SHIFT;
                    end else begin
                        result_d = w_alu_res;
                        state_d  = ST_DONE;
                    end
                end else if ((state_q == ST_DONE) && out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (w_shift_done) begin
                    result_d = w_shift_res;
                    state_d  = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        zero_d = (result_d == '0);
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        in_ready  = !reset && ((state_q == ST_IDLE) ||
                               ((state_q == ST_DONE) && out_ready));
        out_valid = (state_q == ST_DONE);
        busy      = (state_q == ST_SHIFT);
    end

    assign result = result_q;
    assign zero   = zero_q;

endmodule : alu_exec_unit
`default_nettype wire

// File: tb/tb_alu_exec_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_exec_unit
// Purpose  : Directed self-checking testbench for alu_exec_unit.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_exec_unit;
    import alu_pkg::*;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    alu_op_e     operation;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        zero;
    logic        busy;

    int checks = 0;
    int errors = 0;

    alu_exec_unit #(.DATA_W(32), .SHAMT_W(5)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .operation (operation),
        .src_a     (src_a),
        .src_b     (src_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one op with out_ready high, wait (bounded) for its result,
    // capture it, then consume it so the unit is back in IDLE.
    task automatic do_op(input alu_op_e op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] r, output logic z,
                         output int lat, output int busy_n);
        in_valid  = 1'b1;
        operation = op;
        src_a     = a;
        src_b     = b;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        src_a    = 32'hDEAD_0000;
        src_b    = 32'h0000_BEEF;
        lat      = 1;
        busy_n   = 0;
        while (!out_valid && lat < 100) begin
            if (busy) busy_n++;
            tick();
            lat++;
        end
        r = result;
        z = zero;
        tick();
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        operation = OP_AND;
        src_a     = '0;
        src_b     = '0;
        repeat (3) tick();
        checks++; if (in_ready !== 1'b0)  begin errors++; $display("FAIL reset in_ready: got %b expected 0", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset out_valid: got %b expected 0", out_valid); end
        checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL reset busy: got %b expected 0", busy); end
        checks++; if (result !== 32'h0)   begin errors++; $display("FAIL reset result: got %h expected 00000000", result); end
        checks++; if (zero !== 1'b1)      begin errors++; $display("FAIL reset zero: got %b expected 1", zero); end
        reset = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1)  begin errors++; $display("FAIL idle in_ready: got %b expected 1", in_ready); end
        tick();
    endtask

    task automatic test_add_sub();
        logic [31:0] r; logic z; int lat; int bn;
        do_op(OP_ADD, 32'h7FFF_FFFF, 32'h1, r, z, lat, bn);
        checks++; if (lat !== 1)            begin errors++; $display("FAIL add latency: got %0d expected 1", lat); end
        checks++; if (r !== 32'h8000_0000)  begin errors++; $display("FAIL add result: got %h expected 80000000", r); end
        checks++; if (z !== 1'b0)           begin errors++; $display("FAIL add zero: got %b expected 0", z); end
        do_op(OP_SUB, 32'd5, 32'd5, r, z, lat, bn);
        checks++; if (lat !== 1)            begin errors++; $display("FAIL sub latency: got %0d expected 1", lat); end
        checks++; if (r !== 32'h0)          begin errors++; $display("FAIL sub result: got %h expected 00000000", r); end
        checks++; if (z !== 1'b1)           begin errors++; $display("FAIL sub zero: got %b expected 1", z); end
        do_op(OP_SUB, 32'd0, 32'd1, r, z, lat, bn);
        checks++; if (r !== 32'hFFFF_FFFF)  begin errors++; $display("FAIL sub wrap result: got %h expected ffffffff", r); end
    endtask

    task automatic test_logic();
        logic [31:0] r; logic z; int lat; int bn;
        do_op(OP_AND, 32'hFF00_FF00, 32'h0F0F_0F0F, r, z, lat, bn);
        checks++; if (r !== 32'h0F00_0F00)  begin errors++; $display("FAIL and result: got %h expected 0f000f00", r); end
        do_op(OP_OR, 32'hFF00_0000, 32'h0000_00F0, r, z, lat, bn);
        checks++; if (r !== 32'hFF00_00F0)  begin errors++; $display("FAIL or result: got %h expected ff0000f0", r); end
        do_op(OP_SLT, 32'd7, 32'hFFFF_FFF0, r, z, lat, bn);
        checks++; if (r !== 32'h0)          begin errors++; $display("FAIL slt false result: got %h expected 00000000", r); end
        do_op(OP_BEQ, 32'd9, 32'd9, r, z, lat, bn);
        checks++; if (r !== 32'h1)          begin errors++; $display("FAIL beq result: got %h expected 00000001", r); end
    endtask

    task automatic test_shift();
        logic [31:0] r; logic z; int lat; int bn;
        do_op(OP_SRA, 32'h8000_0000, 32'd31, r, z, lat, bn);
        checks++; if (lat !== 32)           begin errors++; $display("FAIL sra latency: got %0d expected 32", lat); end
        checks++; if (bn !== 31)            begin errors++; $display("FAIL sra busy cycles: got %0d expected 31", bn); end
        checks++; if (r !== 32'hFFFF_FFFF)  begin errors++; $display("FAIL sra result: got %h expected ffffffff", r); end
        do_op(OP_SRL, 32'h8000_0000, 32'd31, r, z, lat, bn);
        checks++; if (lat !== 32)           begin errors++; $display("FAIL srl latency: got %0d expected 32", lat); end
        checks++; if (r !== 32'h0000_0001)  begin errors++; $display("FAIL srl result: got %h expected 00000001", r); end
        do_op(OP_SLL, 32'h1234_5678, 32'h20, r, z, lat, bn);
        checks++; if (lat !== 1)            begin errors++; $display("FAIL sll shamt0 latency: got %0d expected 1", lat); end
        checks++; if (r !== 32'h1234_5678)  begin errors++; $display("FAIL sll shamt0 result: got %h expected 12345678", r); end
        do_op(OP_SLL, 32'h0000_0003, 32'hFFFF_FFE4, r, z, lat, bn);
        checks++; if (lat !== 5)            begin errors++; $display("FAIL sll shamt4 latency: got %0d expected 5", lat); end
        checks++; if (r !== 32'h0000_0030)  begin errors++; $display("FAIL sll shamt4 result: got %h expected 00000030", r); end
    endtask

    task automatic test_backpressure();
        in_valid  = 1'b1;
        operation = OP_SLT;
        src_a     = 32'hFFFF_FFFF;
        src_b     = 32'h0;
        out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        src_a    = 32'h0000_0005;
        for (int i = 0; i < 5; i++) begin
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp out_valid cycle %0d: got %b expected 1", i, out_valid); end
            checks++; if (result !== 32'h1)   begin errors++; $display("FAIL bp result cycle %0d: got %h expected 00000001", i, result); end
            checks++; if (in_ready !== 1'b0)  begin errors++; $display("FAIL bp in_ready cycle %0d: got %b expected 0", i, in_ready); end
            tick();
        end
        in_valid  = 1'b1;
        operation = OP_BNE;
        src_a     = 32'd3;
        src_b     = 32'd4;
        out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1)  begin errors++; $display("FAIL bp release in_ready: got %b expected 1", in_ready); end
        tick();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bne out_valid: got %b expected 1", out_valid); end
        checks++; if (result !== 32'h1)   begin errors++; $display("FAIL bne result: got %h expected 00000001", result); end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp drain out_valid: got %b expected 0", out_valid); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] va [8] = '{32'h0000_0000, 32'hFFFF_FFFF, 32'h1234_5678, 32'hAAAA_AAAA,
                                32'h0000_0001, 32'h8000_0000, 32'hDEAD_BEEF, 32'h0000_FFFF};
        logic [31:0] vb [8] = '{32'h0000_0000, 32'h0F0F_0F0F, 32'h1234_5678, 32'h5555_5555,
                                32'h0000_0002, 32'h0000_0001, 32'hFFFF_FFFF, 32'hFFFF_0000};
        logic [31:0] ve [8] = '{32'h0000_0000, 32'hF0F0_F0F0, 32'h0000_0000, 32'hFFFF_FFFF,
                                32'h0000_0003, 32'h8000_0001, 32'h2152_4110, 32'hFFFF_FFFF};
        out_ready = 1'b1;
        operation = OP_XOR;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            src_a    = va[i];
            src_b    = vb[i];
            #1;
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b in_ready op %0d: got %b expected 1", i, in_ready); end
            if (i > 0) begin
                checks++; if (out_valid !== 1'b1)  begin errors++; $display("FAIL b2b out_valid op %0d: got %b expected 1", i - 1, out_valid); end
                checks++; if (result !== ve[i-1])  begin errors++; $display("FAIL b2b result op %0d: got %h expected %h", i - 1, result, ve[i-1]); end
                checks++; if (zero !== (ve[i-1] == 32'h0)) begin errors++; $display("FAIL b2b zero op %0d: got %b expected %b", i - 1, zero, ve[i-1] == 32'h0); end
            end
            tick();
        end
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL b2b out_valid op 7: got %b expected 1", out_valid); end
        checks++; if (result !== ve[7])   begin errors++; $display("FAIL b2b result op 7: got %h expected %h", result, ve[7]); end
        tick();
    endtask

    task automatic test_reset_mid_shift();
        int stale;
        in_valid  = 1'b1;
        operation = OP_SLL;
        src_a     = 32'h1;
        src_b     = 32'd20;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (8) tick();
        checks++; if (busy !== 1'b1)      begin errors++; $display("FAIL midshift busy: got %b expected 1", busy); end
        reset = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b0)  begin errors++; $display("FAIL midshift reset in_ready: got %b expected 0", in_ready); end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midshift out_valid: got %b expected 0", out_valid); end
        checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL midshift busy after reset: got %b expected 0", busy); end
        checks++; if (result !== 32'h0)   begin errors++; $display("FAIL midshift result: got %h expected 00000000", result); end
        checks++; if (zero !== 1'b1)      begin errors++; $display("FAIL midshift zero: got %b expected 1", zero); end
        reset = 1'b0;
        stale = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (out_valid || busy) stale++;
        end
        checks++; if (stale !== 0)        begin errors++; $display("FAIL midshift stale output cycles: got %0d expected 0", stale); end
    endtask

    task automatic test_illegal_branch();
        logic [31:0] r; logic z; int lat; int bn;
        do_op(alu_op_e'(4'b0110), 32'h0000_FFFF, 32'h1, r, z, lat, bn);
        checks++; if (lat !== 1)     begin errors++; $display("FAIL illegal latency: got %0d expected 1", lat); end
        checks++; if (r !== 32'h0)   begin errors++; $display("FAIL illegal result: got %h expected 00000000", r); end
        checks++; if (z !== 1'b1)    begin errors++; $display("FAIL illegal zero: got %b expected 1", z); end
        do_op(OP_BGE, 32'hFFFF_FFFE, 32'hFFFF_FFFE, r, z, lat, bn);
        checks++; if (r !== 32'h1)   begin errors++; $display("FAIL bge result: got %h expected 00000001", r); end
        do_op(OP_BLT, 32'hFFFF_FFFE, 32'h1, r, z, lat, bn);
        checks++; if (r !== 32'h1)   begin errors++; $display("FAIL blt result: got %h expected 00000001", r); end
        checks++; if (z !== 1'b0)    begin errors++; $display("FAIL blt zero: got %b expected 0", z); end
        do_op(OP_BNE, 32'd4, 32'd4, r, z, lat, bn);
        checks++; if (r !== 32'h0)   begin errors++; $display("FAIL bne equal result: got %h expected 00000000", r); end
    endtask

    initial begin
        test_reset();
        test_add_sub();
        test_logic();
        test_shift();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_shift();
        test_illegal_branch();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_alu_exec_unit
`default_nettype wire
